// File: rtl/simple_reg_initiator.sv
// simple_reg_initiator
//   Drives one hash core's req/rsp register bus for a single message block.
//   The sequence is: optional CTRL reset write, block register writes, CTRL
//   enable write, CTRL polling until valid, then digest register reads. The
//   digest is returned upstream.
// Ports
//   clk_i, rst_i (sync, active-high)
//   block_i/init_i/block_valid_i/block_ready_o : upstream block port
//   digest_o/digest_valid_o/error_o/busy_o     : result and status
//   req*_o / reqready_i                        : bus request channel
//   rspready_o / rspvalid_i/rspdata_i/rsperror_i : bus response channel
module simple_reg_initiator #(
   parameter int DataWidth     = 64,
   parameter int AddrWidth     = 32,
   parameter int BlockWidth    = 512,
   parameter int DigestWidth   = 256,
   parameter bit ByteAlign     = 1'b1,
   parameter logic [AddrWidth-1:0] BaseAddr = '0,
   parameter int TimeoutCycles = 16,
   parameter int PollLimit     = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [BlockWidth-1:0]  block_i,
   input  logic                   init_i,
   input  logic                   block_valid_i,
   output logic                   block_ready_o,
   output logic [DigestWidth-1:0] digest_o,
   output logic                   digest_valid_o,
   output logic                   error_o,
   output logic                   busy_o,
   output logic [DataWidth-1:0]   reqdata_o,
   output logic [AddrWidth-1:0]   reqaddr_o,
   output logic                   reqvalid_o,
   output logic                   reqwrite_o,
   input  logic                   reqready_i,
   output logic [DataWidth/8-1:0] reqstrobe_o,
   output logic                   rspready_o,
   input  logic                   rspvalid_i,
   input  logic [DataWidth-1:0]   rspdata_i,
   input  logic                   rsperror_i
);
   localparam int NBl   = BlockWidth / DataWidth;
   localparam int NDi   = (DigestWidth + DataWidth - 1) / DataWidth;
   localparam int NMax  = (NBl > NDi) ? NBl : NDi;
   localparam int IdxW  = $clog2(NMax + 1);
   localparam int TmoW  = $clog2(TimeoutCycles + 1);
   localparam int PollW = $clog2(PollLimit + 1);
   localparam logic [AddrWidth-1:0] Step     = AddrWidth'(ByteAlign ? DataWidth / 8 : DataWidth / 32);
   localparam logic [AddrWidth-1:0] BlkOffs  = AddrWidth'(32'h100);
   localparam logic [AddrWidth-1:0] DigOffs  = AddrWidth'(32'h200);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_RST, S_WR_BLK, S_WR_EN, S_POLL, S_RD_DIG, S_DONE, S_ERR
   } state_t;

   state_t                   state_q, state_d;
   logic                     wait_q, wait_d;   // 0: ISSUE phase, 1: WAIT phase
   logic [IdxW-1:0]          idx_q, idx_d;
   logic [TmoW-1:0]          tmo_q, tmo_d;
   logic [PollW-1:0]         poll_q, poll_d;
   logic [BlockWidth-1:0]    blk_q;
   logic [NDi*DataWidth-1:0] dig_buf_q, dig_next;
   logic [DigestWidth-1:0]   digest_q;
   logic                     access, accept, cap, last_dig;
   logic [DataWidth-1:0]     blk_word;

   assign access   = (state_q == S_WR_RST) || (state_q == S_WR_BLK) || (state_q == S_WR_EN) ||
                     (state_q == S_POLL)   || (state_q == S_RD_DIG);
   assign accept   = (state_q == S_IDLE) && block_valid_i;
   assign cap      = (state_q == S_RD_DIG) && wait_q && rspvalid_i && !rsperror_i;
   assign last_dig = (idx_q == IdxW'(NDi - 1));

   // Partial digest words collect in dig_buf_q; digest_o only changes when
   // the final word lands, so an aborted read never disturbs it.
   always_comb begin
      dig_next = dig_buf_q;
      for (int d = 0; d < NDi; d++)
         if (cap && idx_q == IdxW'(d)) dig_next[d*DataWidth +: DataWidth] = rspdata_i;
   end

   always_comb begin
      blk_word = '0;
      for (int r = 0; r < NBl; r++)
         if (idx_q == IdxW'(r)) blk_word = blk_q[r*DataWidth +: DataWidth];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         wait_q    <= 1'b0;
         idx_q     <= '0;
         tmo_q     <= '0;
         poll_q    <= '0;
         blk_q     <= '0;
         dig_buf_q <= '0;
         digest_q  <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         idx_q     <= idx_d;
         tmo_q     <= tmo_d;
         poll_q    <= poll_d;
         dig_buf_q <= dig_next;
         if (accept) blk_q <= block_i;
         if (cap && last_dig) digest_q <= dig_next[DigestWidth-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      idx_d   = idx_q;
      tmo_d   = tmo_q;
      poll_d  = poll_q;
      case (state_q)
         S_IDLE: begin
            if (block_valid_i) begin
               state_d = init_i ? S_WR_RST : S_WR_BLK;
               idx_d   = '0;
               wait_d  = 1'b0;
            end
         end
         S_DONE, S_ERR: state_d = S_IDLE;
         default: begin
            if (!wait_q) begin
               if (reqready_i) begin
                  wait_d = 1'b1;
                  tmo_d  = '0;
               end
            end else if (rsperror_i) begin
               wait_d  = 1'b0;
               state_d = S_ERR;
            end else if (rspvalid_i) begin
               wait_d = 1'b0;
               case (state_q)
                  S_WR_RST: begin
                     state_d = S_WR_BLK;
                     idx_d   = '0;
                  end
                  S_WR_BLK: begin
                     if (idx_q == IdxW'(NBl - 1)) state_d = S_WR_EN;
                     else                         idx_d   = idx_q + 1'b1;
                  end
                  S_WR_EN: begin
                     state_d = S_POLL;
                     poll_d  = '0;
                  end
                  S_POLL: begin
                     if (rspdata_i[4]) begin
                        state_d = S_RD_DIG;
                        idx_d   = '0;
                     end else if (poll_q == PollW'(PollLimit - 1)) begin
                        state_d = S_ERR;
                     end else begin
                        poll_d  = poll_q + 1'b1;
                     end
                  end
                  S_RD_DIG: begin
                     if (last_dig) state_d = S_DONE;
                     else          idx_d   = idx_q + 1'b1;
                  end
                  default: state_d = S_ERR;
               endcase
            end else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
               wait_d  = 1'b0;
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      reqaddr_o  = '0;
      reqdata_o  = '0;
      reqwrite_o = 1'b0;
      case (state_q)
         S_WR_RST: begin
            reqaddr_o  = BaseAddr;
            reqdata_o  = DataWidth'(2);
            reqwrite_o = 1'b1;
         end
         S_WR_BLK: begin
            reqaddr_o  = BaseAddr + BlkOffs + AddrWidth'(idx_q) * Step;
            reqdata_o  = blk_word;
            reqwrite_o = 1'b1;
         end
         S_WR_EN: begin
            reqaddr_o  = BaseAddr;
            reqdata_o  = DataWidth'(1);
            reqwrite_o = 1'b1;
         end
         S_POLL:   reqaddr_o = BaseAddr;
         S_RD_DIG: reqaddr_o = BaseAddr + DigOffs + AddrWidth'(idx_q) * Step;
         default: ;
      endcase
   end

   assign reqvalid_o     = access && !wait_q;
   assign rspready_o     = access;
   assign reqstrobe_o    = reqwrite_o ? '1 : '0;
   assign block_ready_o  = (state_q == S_IDLE) && !rst_i;
   assign busy_o         = (state_q != S_IDLE);
   assign digest_valid_o = (state_q == S_DONE);
   assign error_o        = (state_q == S_ERR);
   assign digest_o       = digest_q;
endmodule
